dino_game_engine: RTL and testbench

- Multi-obstacle game-state engine for the runner game. Owns player jump physics, NUM_OBS independently moving obstacles, a pattern-driven obstacle height sequence, difficulty ramp (speed-up), collision detection, score, and an IDLE/RUN/OVER state machine.
- Advances once per clk_20Hz tick.
- Outputs registered world coordinates that the pixel renderer consumes.

---
 rtl/dino_game_engine.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_dino_game_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dino_game_engine
//  Description : Game-state engine for the runner game. Advances one step per
//                game tick: player jump physics, NUM_OBS scrolling obstacles
//                with pattern-driven heights, difficulty ramp, collision
//                detection, saturating score and IDLE/RUN/OVER control.
//  Revision    : 1.0 - initial release
// ============================================================================
module dino_game_engine #(
    parameter int NUM_OBS          = 3,
    parameter int COORD_W          = 11,
    parameter int SCORE_W          = 11,
    parameter int PATTERN_W        = 16,
    parameter int PLAYER_BASE      = 400,
    parameter int PLAYER_LEFT      = 100,
    parameter int PLAYER_W         = 20,
    parameter int PLAYER_H         = 40,
    parameter int OBS_W            = 20,
    parameter int OBS_H            = 20,
    parameter int SPAWN_X          = 600,
    parameter int OBS_SPACING      = 200,
    parameter int RESPAWN_X        = 600,
    parameter int LOW_Y            = 400,
    parameter int HIGH_Y           = 350,
    parameter int SPEED_INIT       = 5,
    parameter int SPEED_MAX        = 15,
    parameter int SPEED_STEP_SCORE = 10,
    parameter int JUMP_STEP        = 3,
    parameter int JUMP_PEAK        = 48
) (
    input  logic                         clk_20Hz,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         jump,
    input  logic [PATTERN_W-1:0]         pattern,
    output logic [COORD_W-1:0]           player_bottom,
    output logic [NUM_OBS*COORD_W-1:0]   obs_x,
    output logic [NUM_OBS*COORD_W-1:0]   obs_y,
    output logic [SCORE_W-1:0]           score,
    output logic [4:0]                   speed,
    output logic                         running,
    output logic                         game_over
);

    // ------------------------------------------------------------------------
    // Derived widths and sized constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam int CNT_W = $clog2(SPEED_STEP_SCORE + NUM_OBS + 1);
    localparam int RET_W = $clog2(NUM_OBS + 1);

    // Collision terms are evaluated one bit wider so sums never wrap.
    localparam logic [COORD_W:0]   C_PL_RIGHT   = (COORD_W+1)'(PLAYER_LEFT + PLAYER_W);
    localparam logic [COORD_W:0]   C_PL_LEFT    = (COORD_W+1)'(PLAYER_LEFT);
    localparam logic [COORD_W:0]   C_OBS_W      = (COORD_W+1)'(OBS_W);
    localparam logic [COORD_W:0]   C_OBS_H      = (COORD_W+1)'(OBS_H);
    localparam logic [COORD_W:0]   C_PL_H       = (COORD_W+1)'(PLAYER_H);

    localparam logic [COORD_W-1:0] C_BASE       = COORD_W'(PLAYER_BASE);
    localparam logic [COORD_W-1:0] C_RESPAWN    = COORD_W'(RESPAWN_X);
    localparam logic [COORD_W-1:0] C_LOW_Y      = COORD_W'(LOW_Y);
    localparam logic [COORD_W-1:0] C_HIGH_Y     = COORD_W'(HIGH_Y);
    localparam logic [COORD_W-1:0] C_JSTEP      = COORD_W'(JUMP_STEP);
    localparam logic [COORD_W-1:0] C_JPEAK      = COORD_W'(JUMP_PEAK);
    localparam logic [4:0]         C_SPEED_INIT = 5'(SPEED_INIT);
    localparam logic [4:0]         C_SPEED_MAX  = 5'(SPEED_MAX);
    localparam logic [CNT_W-1:0]   C_STEP       = CNT_W'(SPEED_STEP_SCORE);
    localparam logic [IDX_W-1:0]   C_IDX_INIT   = IDX_W'(NUM_OBS % PATTERN_W);
    localparam logic [IDX_W-1:0]   C_IDX_LAST   = IDX_W'(PATTERN_W - 1);

    // Game control states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    // Jump phases
    localparam logic [1:0] J_GROUND = 2'd0;
    localparam logic [1:0] J_RISE   = 2'd1;
    localparam logic [1:0] J_FALL   = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          r_jphase;
    logic [COORD_W-1:0]  r_height;
    logic [COORD_W-1:0]  r_player_bottom;
    logic [COORD_W-1:0]  r_obs_x [NUM_OBS];
    logic [COORD_W-1:0]  r_obs_y [NUM_OBS];
    logic [IDX_W-1:0]    r_idx;
    logic [SCORE_W-1:0]  r_score;
    logic [4:0]          r_speed;
    logic [CNT_W-1:0]    r_spd_cnt;

    // ------------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic                w_collide;
    logic                w_init;
    logic                w_advance;
    logic [1:0]          w_jphase_nxt;
    logic [COORD_W-1:0]  w_height_nxt;
    logic [COORD_W-1:0]  w_rise_height;
    logic [COORD_W-1:0]  w_obs_x_nxt [NUM_OBS];
    logic [COORD_W-1:0]  w_obs_y_nxt [NUM_OBS];
    logic [IDX_W-1:0]    w_idx;
    logic [RET_W-1:0]    w_retired;
    logic [SCORE_W:0]    w_score_sum;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic [CNT_W-1:0]    w_cnt_sum;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [4:0]          w_speed_nxt;

    // Init happens on a start request from either resting state; otherwise
    // the world advances only on a RUN tick that did not end in a hit.
    assign w_init    = start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_advance = (r_state == S_RUN) && !w_collide;

    // Bounding-box overlap of the player against every obstacle, using the
    // values currently on the outputs.
    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (({1'b0, r_obs_x[i]} < C_PL_RIGHT) &&
                (({1'b0, r_obs_x[i]} + C_OBS_W) > C_PL_LEFT) &&
                (({1'b0, r_player_bottom} + C_OBS_H) > {1'b0, r_obs_y[i]}) &&
                ({1'b0, r_player_bottom} < ({1'b0, r_obs_y[i]} + C_PL_H))) begin
                w_collide = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: start is honoured only outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_state_nxt = S_RUN;
            S_RUN:   if (w_collide) w_state_nxt = S_OVER;
            S_OVER:  if (start)     w_state_nxt = S_RUN;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        running   = (r_state == S_RUN);
        game_over = (r_state == S_OVER);
    end

    // Obstacle motion and retirement; retirements consume pattern bits in
    // ascending obstacle order within one tick.
    always_comb begin
        w_idx     = r_idx;
        w_retired = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            w_obs_x_nxt[i] = r_obs_x[i];
            w_obs_y_nxt[i] = r_obs_y[i];
        end
        if (w_init) begin
            w_idx = C_IDX_INIT;
            for (int i = 0; i < NUM_OBS; i++) begin
                w_obs_x_nxt[i] = COORD_W'(SPAWN_X + i * OBS_SPACING);
                w_obs_y_nxt[i] = pattern[i % PATTERN_W] ? C_HIGH_Y : C_LOW_Y;
            end
        end else if (w_advance) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (r_obs_x[i] < COORD_W'(r_speed)) begin
                    w_obs_x_nxt[i] = C_RESPAWN;
                    w_obs_y_nxt[i] = pattern[w_idx] ? C_HIGH_Y : C_LOW_Y;
                    w_idx          = (w_idx == C_IDX_LAST) ? '0 : w_idx + IDX_W'(1);
                    w_retired      = w_retired + RET_W'(1);
                end else begin
                    w_obs_x_nxt[i] = r_obs_x[i] - COORD_W'(r_speed);
                end
            end
        end
    end

    // Saturating score and the difficulty ramp driven by the retire count.
    always_comb begin
        w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_retired);
        w_cnt_sum   = r_spd_cnt + CNT_W'(w_retired);
        w_score_nxt = r_score;
        w_cnt_nxt   = r_spd_cnt;
        w_speed_nxt = r_speed;
        if (w_init) begin
            w_score_nxt = '0;
            w_cnt_nxt   = '0;
            w_speed_nxt = C_SPEED_INIT;
        end else if (w_advance) begin
            w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
            if (w_cnt_sum >= C_STEP) begin
                w_cnt_nxt   = w_cnt_sum - C_STEP;
                w_speed_nxt = (r_speed < C_SPEED_MAX) ? r_speed + 5'd1 : r_speed;
            end else begin
                w_cnt_nxt   = w_cnt_sum;
            end
        end
    end

    // Jump physics: the accept tick only arms the rise, height moves after.
    always_comb begin
        w_jphase_nxt  = r_jphase;
        w_height_nxt  = r_height;
        w_rise_height = r_height + C_JSTEP;
        if (w_init) begin
            w_jphase_nxt = J_GROUND;
            w_height_nxt = '0;
        end else if (w_advance) begin
            case (r_jphase)
                J_GROUND: begin
                    if (jump) w_jphase_nxt = J_RISE;
                end
                J_RISE: begin
                    w_height_nxt = w_rise_height;
                    if (w_rise_height >= C_JPEAK) w_jphase_nxt = J_FALL;
                end
                J_FALL: begin
                    if (r_height <= C_JSTEP) begin
                        w_height_nxt = '0;
                        w_jphase_nxt = J_GROUND;
                    end else begin
                        w_height_nxt = r_height - C_JSTEP;
                    end
                end
                default: begin
                    w_height_nxt = '0;
                    w_jphase_nxt = J_GROUND;
                end
            endcase
        end
    end

    // World-state registers feeding the renderer.
    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            r_jphase        <= J_GROUND;
            r_height        <= '0;
            r_player_bottom <= C_BASE;
            r_idx           <= '0;
            r_score         <= '0;
            r_speed         <= C_SPEED_INIT;
            r_spd_cnt       <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_obs_x[i] <= COORD_W'(SPAWN_X + i * OBS_SPACING);
                r_obs_y[i] <= C_LOW_Y;
            end
        end else begin
            r_jphase        <= w_jphase_nxt;
            r_height        <= w_height_nxt;
            r_player_bottom <= C_BASE - w_height_nxt;
            r_idx           <= w_idx;
            r_score         <= w_score_nxt;
            r_speed         <= w_speed_nxt;
            r_spd_cnt       <= w_cnt_nxt;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_obs_x[i] <= w_obs_x_nxt[i];
                r_obs_y[i] <= w_obs_y_nxt[i];
            end
        end
    end

    // Pack per-obstacle coordinates onto the output buses.
    generate
        for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
            assign obs_x[g*COORD_W +: COORD_W] = r_obs_x[g];
            assign obs_y[g*COORD_W +: COORD_W] = r_obs_y[g];
        end
    endgenerate

    assign player_bottom = r_player_bottom;
    assign score         = r_score;
    assign speed         = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_dino_game_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dino_game_engine
//  Description : Directed self-checking bench for dino_game_engine. A second
//                instance with SPEED_MAX=6 and SCORE_W=4 runs an all-high
//                pattern in the background for the cap/saturation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_game_engine;

    logic        clk_20Hz = 1'b0;
    logic        rst, start, jump;
    logic [15:0] pattern;
    logic [10:0] player_bottom;
    logic [32:0] obs_x, obs_y;
    logic [10:0] score;
    logic [4:0]  speed;
    logic        running, game_over;

    logic        rst2, start2, jump2;
    logic [15:0] pattern2;
    logic [10:0] player_bottom2;
    logic [32:0] obs_x2, obs_y2;
    logic [3:0]  score2;
    logic [4:0]  speed2;
    logic        running2, game_over2;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  max_speed2   = '0;
    logic [3:0]  prev_score2  = '0;
    logic        score2_wrap  = 1'b0;

    always #5 clk_20Hz = ~clk_20Hz;

    dino_game_engine dut (
        .clk_20Hz      (clk_20Hz),
        .rst           (rst),
        .start         (start),
        .jump          (jump),
        .pattern       (pattern),
        .player_bottom (player_bottom),
        .obs_x         (obs_x),
        .obs_y         (obs_y),
        .score         (score),
        .speed         (speed),
        .running       (running),
        .game_over     (game_over)
    );

    dino_game_engine #(.SPEED_MAX(6), .SCORE_W(4)) dut2 (
        .clk_20Hz      (clk_20Hz),
        .rst           (rst2),
        .start         (start2),
        .jump          (jump2),
        .pattern       (pattern2),
        .player_bottom (player_bottom2),
        .obs_x         (obs_x2),
        .obs_y         (obs_y2),
        .score         (score2),
        .speed         (speed2),
        .running       (running2),
        .game_over     (game_over2)
    );

    logic [10:0] ox0, ox1, ox2, oy0, oy1, oy2;
    assign ox0 = obs_x[10:0];
    assign ox1 = obs_x[21:11];
    assign ox2 = obs_x[32:22];
    assign oy0 = obs_y[10:0];
    assign oy1 = obs_y[21:11];
    assign oy2 = obs_y[32:22];

    // Track the capped instance: highest speed seen and any score decrease.
    always @(negedge clk_20Hz) begin
        if (speed2 > max_speed2) max_speed2 = speed2;
        if (score2 < prev_score2) score2_wrap = 1'b1;
        prev_score2 = score2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_20Hz);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; jump = 1'b0; pattern = '0;
        rst2 = 1'b1; start2 = 1'b0; jump2 = 1'b0; pattern2 = 16'hFFFF;
        #12;
        check_eq("rst_running", running, 0);
        check_eq("rst_over", game_over, 0);
        check_eq("rst_score", score, 0);
        check_eq("rst_speed", speed, 5);
        check_eq("rst_bottom", player_bottom, 400);
        check_eq("rst_x0", ox0, 600);
        check_eq("rst_x1", ox1, 800);
        check_eq("rst_x2", ox2, 1000);
        check_eq("rst_y0", oy0, 400);
        rst = 1'b0; rst2 = 1'b0;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        check_eq("d2_running", running2, 1);

        // IDLE holds without start
        tick(2);
        check_eq("idle_running", running, 0);
        check_eq("idle_x0", ox0, 600);

        // Grounded player meets a low obstacle at x=115
        pattern = 16'h0000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("a_running", running, 1);
        check_eq("a_x0", ox0, 600);
        check_eq("a_y2", oy2, 400);
        tick(97);
        check_eq("a_x0_115", ox0, 115);
        check_eq("a_not_over", game_over, 0);
        tick(1);
        check_eq("a_over", game_over, 1);
        check_eq("a_not_running", running, 0);
        check_eq("a_x0_frozen", ox0, 115);
        check_eq("a_x1_frozen", ox1, 315);
        check_eq("a_score", score, 0);
        jump = 1'b1;
        tick(3);
        check_eq("over_jump_ign", player_bottom, 400);
        check_eq("over_x0_hold", ox0, 115);

        // Restart from OVER with jump held high
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("r_running", running, 1);
        check_eq("r_over", game_over, 0);
        check_eq("r_score", score, 0);
        check_eq("r_speed", speed, 5);
        check_eq("r_x0", ox0, 600);
        check_eq("r_x2", ox2, 1000);
        check_eq("r_bottom", player_bottom, 400);
        tick(1);
        check_eq("j_accept", player_bottom, 400);
        tick(1);
        check_eq("j_t1", player_bottom, 397);
        tick(15);
        check_eq("j_peak", player_bottom, 352);
        tick(16);
        check_eq("j_land", player_bottom, 400);
        tick(1);
        check_eq("j_reaccept", player_bottom, 400);
        tick(1);
        check_eq("j_rerise", player_bottom, 397);
        jump = 1'b0;
        tick(70);
        check_eq("r_ends_over", game_over, 1);

        // Jump timed at x=200 clears the low obstacle, which then scores
        pattern = 16'h0000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(80);
        check_eq("b_x0_200", ox0, 200);
        jump = 1'b1;
        tick(1);
        jump = 1'b0;
        check_eq("b_accept_x0", ox0, 195);
        check_eq("b_accept_bot", player_bottom, 400);
        tick(16);
        check_eq("b_x0_115", ox0, 115);
        check_eq("b_bottom_352", player_bottom, 352);
        check_eq("b_no_hit", game_over, 0);
        tick(23);
        check_eq("b_x0_0", ox0, 0);
        check_eq("b_score0", score, 0);
        check_eq("b_landed", player_bottom, 400);
        tick(1);
        check_eq("b_score1", score, 1);
        check_eq("b_respawn", ox0, 600);
        check_eq("b_resp_y", oy0, 400);
        check_eq("b_x1", ox1, 195);
        tick(20);
        check_eq("b_over", game_over, 1);
        check_eq("b_score_hold", score, 1);

        // High obstacle 0 passes over a grounded player
        pattern = 16'h0001;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("c_y0_high", oy0, 350);
        check_eq("c_y1_low", oy1, 400);
        tick(120);
        check_eq("c_x0_0", ox0, 0);
        check_eq("c_no_hit", game_over, 0);
        tick(1);
        check_eq("c_score1", score, 1);
        check_eq("c_respawn", ox0, 600);
        check_eq("c_resp_y", oy0, 400);
        tick(16);
        check_eq("c_pre_hit", game_over, 0);
        tick(1);
        check_eq("c_o1_hit", game_over, 1);

        // Jumping into the high obstacle collides
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(80);
        jump = 1'b1;
        tick(1);
        jump = 1'b0;
        tick(16);
        check_eq("c2_x0_115", ox0, 115);
        check_eq("c2_not_yet", game_over, 0);
        tick(1);
        check_eq("c2_hit", game_over, 1);
        check_eq("c2_x0_frozen", ox0, 115);
        check_eq("c2_bot_frozen", player_bottom, 352);
        check_eq("c2_score", score, 0);

        // Ten passes raise the speed
        pattern = 16'hFFFF;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("d_y0", oy0, 350);
        tick(483);
        check_eq("d_score9", score, 9);
        check_eq("d_speed5", speed, 5);
        tick(1);
        check_eq("d_score10", score, 10);
        check_eq("d_speed6", speed, 6);
        check_eq("d_x0_resp", ox0, 600);
        tick(1);
        check_eq("d_x0_fast", ox0, 594);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("d_start_ign", running, 1);
        check_eq("d_x0_588", ox0, 588);

        // Asynchronous reset mid-RUN
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_running", running, 0);
        check_eq("ar_x0", ox0, 600);
        check_eq("ar_x1", ox1, 800);
        check_eq("ar_x2", ox2, 1000);
        check_eq("ar_score", score, 0);
        check_eq("ar_speed", speed, 5);
        check_eq("ar_bottom", player_bottom, 400);
        rst = 1'b0;
        tick(2);
        check_eq("ar_idle", running, 0);
        check_eq("ar_idle_x0", ox0, 600);

        // Capped instance results
        check_eq("d2_score_sat", score2, 15);
        check_eq("d2_speed_cap", speed2, 6);
        check_eq("d2_max_speed", max_speed2, 6);
        check_eq("d2_no_wrap", score2_wrap, 0);
        check_eq("d2_still_run", running2, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
